// File: rtl/adc_capture_train_if.sv
// adc_capture_train_if: pin, control and status bundle for adc_capture_train
// master: drives inp/inn/fmt/train_start, observes dout/dval/state/bad_bits
// slave:  the capture block; channel c occupies [c*pincount +: pincount]
interface adc_capture_train_if #(
  parameter int pincount = 16,
  parameter int nchan = 2
);
  logic [nchan*pincount-1:0] inp, inn, dout, bad_bits;
  logic fmt, train_start;
  logic [nchan-1:0] dval;
  logic [2*nchan-1:0] state;
  modport master (output inp, inn, fmt, train_start, input dout, dval, state, bad_bits);
  modport slave (input inp, inn, fmt, train_start, output dout, dval, state, bad_bits);
endinterface

// File: rtl/adc_capture_train.sv
// adc_capture_train: parallel-LVDS ADC capture with per-channel link training
// clk: ADC data clock; rst_n: async active-low reset, released synchronously
// bus.inp/inn: differential pins; bus.fmt: 1 = two's complement out
// bus.train_start: restart training; bus.dout/dval/state/bad_bits: per-channel results
module adc_capture_train #(
  parameter int pincount = 16,
  parameter int nchan = 2,
  parameter logic [pincount-1:0] train_pattern = 16'h5555,
  parameter int lock_count = 64,
  parameter int timeout_cycles = 4095
) (
  input logic clk,
  input logic rst_n,
  adc_capture_train_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, TRAIN = 2'd1, LOCKED = 2'd2, FAIL = 2'd3;
  localparam logic [15:0] LOCK_N = 16'(lock_count);
  localparam logic [15:0] TMO_N = 16'(timeout_cycles);
  logic [1:0] rs_q;
  logic rs_n;
  logic [nchan-1:0][pincount-1:0] dout_w, bad_w;
  logic [nchan-1:0][1:0] st_w;
  logic [nchan-1:0] dval_w;
  // assertion is immediate, release is retimed to clk
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rs_q <= '0;
    else rs_q <= {rs_q[0], 1'b1};
  assign rs_n = rs_q[1];
  for (genvar c = 0; c < nchan; c++) begin : g_ch
    logic [pincount-1:0] pin, s1_q, s2_q, prev_q, dout_q, dout_d, bad_q, bad_d;
    logic [15:0] mcnt_q, mcnt_d, tcnt_q, tcnt_d, minc, tinc;
    logic [1:0] st_q, st_d;
    logic chk_en, match, lock, tmo;
    // behavioural stand-in for the terminated differential input buffer
    assign pin = bus.inp[c*pincount +: pincount] & ~bus.inn[c*pincount +: pincount];
    assign dout_d = s2_q ^ {bus.fmt, {(pincount-1){1'b0}}};
    // tcnt is 0 only in the warm-up cycle right after entering TRAIN
    assign chk_en = st_q == TRAIN && tcnt_q != 16'd0;
    assign match = (s2_q == train_pattern || s2_q == ~train_pattern) && s2_q == ~prev_q;
    assign minc = &mcnt_q ? mcnt_q : mcnt_q + 16'd1;
    assign tinc = &tcnt_q ? tcnt_q : tcnt_q + 16'd1;
    assign lock = chk_en && match && minc >= LOCK_N;
    assign tmo = st_q == TRAIN && tinc >= TMO_N;
    always_comb begin
      st_d = bus.train_start ? TRAIN : lock ? LOCKED : tmo ? FAIL : st_q;
      mcnt_d = bus.train_start ? '0 : chk_en ? (match ? minc : '0) : mcnt_q;
      tcnt_d = bus.train_start ? '0 : st_q == TRAIN ? tinc : tcnt_q;
      bad_d = bus.train_start ? '0 : chk_en ? bad_q | (s2_q ^ ~prev_q) : bad_q;
    end
    always_ff @(posedge clk or negedge rs_n)
      if (!rs_n) begin
        s1_q <= '0;
        s2_q <= '0;
        prev_q <= '0;
        dout_q <= '0;
        bad_q <= '0;
        mcnt_q <= '0;
        tcnt_q <= '0;
        st_q <= IDLE;
      end else begin
        s1_q <= pin;
        s2_q <= s1_q;
        prev_q <= s2_q;
        dout_q <= dout_d;
        bad_q <= bad_d;
        mcnt_q <= mcnt_d;
        tcnt_q <= tcnt_d;
        st_q <= st_d;
      end
    assign dout_w[c] = dout_q;
    assign bad_w[c] = bad_q;
    assign st_w[c] = st_q;
    assign dval_w[c] = st_q == LOCKED;
  end
  assign bus.dout = dout_w;
  assign bus.bad_bits = bad_w;
  assign bus.state = st_w;
  assign bus.dval = dval_w;
endmodule

// File: tb/tb_adc_capture_train.sv
// tb_adc_capture_train: directed checks of capture, format and training behaviour
module tb_adc_capture_train;
  localparam logic [15:0] P = 16'h5555;
  localparam logic [15:0] G = 16'h1234;
  typedef struct {
    logic [15:0] p0, p1;
    logic fmt;
    logic [15:0] e0, e1;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  logic pat_en, phase;
  logic glitch;
  logic [15:0] fix0, fix1, stuck, glitch_orig;
  int passed = 0;
  int total = 0;
  int n;
  vec_t vecs[6];
  adc_capture_train_if #(.pincount(16), .nchan(2)) bus();
  adc_capture_train #(
    .pincount(16), .nchan(2), .train_pattern(P), .lock_count(64), .timeout_cycles(4095)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  // drive one word per channel, then let one rising edge pass
  task automatic cyc();
    logic [15:0] w, a, b;
    if (pat_en) begin
      w = phase ? ~P : P;
      phase = ~phase;
      a = w;
      b = w & ~stuck;
      if (glitch) begin
        glitch_orig = w;
        a = G;
        b = G;
        glitch = 1'b0;
      end
    end else begin
      a = fix0;
      b = fix1;
    end
    bus.inp = {b, a};
    bus.inn = ~{b, a};
    @(negedge clk);
  endtask
  task automatic run_until(input int ch, input logic [1:0] st, input int limit, output int cnt);
    cnt = 0;
    while (cnt < limit && bus.state[2*ch +: 2] != st) begin
      cyc();
      cnt++;
    end
  endtask
  task automatic start_train();
    bus.train_start = 1'b1;
    cyc();
    bus.train_start = 1'b0;
  endtask
  initial begin
    vecs[0] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 16'h8000};
    vecs[1] = '{16'h8000, 16'h7fff, 1'b1, 16'h0000, 16'hffff};
    vecs[2] = '{16'h0000, 16'hffff, 1'b1, 16'h8000, 16'h7fff};
    vecs[3] = '{16'h1234, 16'habcd, 1'b0, 16'h1234, 16'habcd};
    vecs[4] = '{16'h1234, 16'habcd, 1'b1, 16'h9234, 16'h2bcd};
    vecs[5] = '{16'hffff, 16'h0001, 1'b1, 16'h7fff, 16'h8001};
    rst_n = 1'b0;
    bus.train_start = 1'b0;
    bus.fmt = 1'b0;
    bus.inp = '0;
    bus.inn = '1;
    pat_en = 1'b0;
    phase = 1'b0;
    glitch = 1'b0;
    glitch_orig = '0;
    fix0 = 16'hffff;
    fix1 = 16'hffff;
    stuck = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", 64'(bus.state), 64'h0);
    chk("rst_dval", 64'(bus.dval), 64'h0);
    chk("rst_dout", 64'(bus.dout), 64'h0);
    chk("rst_bad", 64'(bus.bad_bits), 64'h0);
    rst_n = 1'b1;
    repeat (3) cyc();
    for (int i = 0; i < 6; i++) begin
      fix0 = vecs[i].p0;
      fix1 = vecs[i].p1;
      bus.fmt = vecs[i].fmt;
      repeat (3) cyc();
      chk($sformatf("fmt_vec%0d", i), 64'(bus.dout), 64'({vecs[i].e1, vecs[i].e0}));
    end
    chk("idle_state", 64'(bus.state), 64'h0);
    fix0 = 16'h8000;
    fix1 = 16'h8000;
    bus.fmt = 1'b0;
    repeat (3) cyc();
    chk("fmt0_8000", 64'(bus.dout), 64'h8000_8000);
    bus.fmt = 1'b1;
    cyc();
    chk("fmt1_next_edge", 64'(bus.dout), 64'h0000_0000);
    bus.fmt = 1'b0;
    fix0 = 16'h1111;
    cyc();
    chk("lat_edge1", 64'(bus.dout), 64'h8000_8000);
    cyc();
    chk("lat_edge2", 64'(bus.dout), 64'h8000_8000);
    cyc();
    chk("lat_edge3", 64'(bus.dout), 64'h8000_1111);
    pat_en = 1'b1;
    repeat (4) cyc();
    start_train();
    chk("ideal_train_entry", 64'(bus.state), 64'h5);
    run_until(0, 2'd2, 200, n);
    chk("ideal_lock_edges", 64'(n), 64'd65);
    chk("ideal_state", 64'(bus.state), 64'ha);
    chk("ideal_dval", 64'(bus.dval), 64'h3);
    chk("ideal_bad", 64'(bus.bad_bits), 64'h0);
    start_train();
    repeat (64) cyc();
    bus.train_start = 1'b1;
    cyc();
    bus.train_start = 1'b0;
    chk("start_on_lock_state", 64'(bus.state), 64'h5);
    chk("start_on_lock_dval", 64'(bus.dval), 64'h0);
    run_until(0, 2'd2, 200, n);
    chk("relock_edges", 64'(n), 64'd65);
    stuck = 16'h0008;
    repeat (3) cyc();
    start_train();
    run_until(1, 2'd3, 5000, n);
    chk("stuck_fail_edges", 64'(n), 64'd4095);
    chk("stuck_state", 64'(bus.state), 64'he);
    chk("stuck_bad", 64'(bus.bad_bits), 64'h0008_0000);
    chk("stuck_dval", 64'(bus.dval), 64'h1);
    stuck = '0;
    repeat (3) cyc();
    start_train();
    chk("retrain_dval", 64'(bus.dval), 64'h0);
    chk("retrain_bad", 64'(bus.bad_bits), 64'h0);
    chk("retrain_state", 64'(bus.state), 64'h5);
    run_until(1, 2'd2, 200, n);
    chk("retrain_lock_edges", 64'(n), 64'd65);
    chk("retrain_locked", 64'(bus.state), 64'ha);
    start_train();
    for (int k = 1; k <= 106; k++) begin
      if (k == 40) glitch = 1'b1;
      cyc();
    end
    chk("glitch_no_early_lock", 64'(bus.state), 64'h5);
    cyc();
    chk("glitch_lock_edge107", 64'(bus.state), 64'ha);
    chk("glitch_bad", 64'(bus.bad_bits), 64'({G ^ glitch_orig, G ^ glitch_orig}));
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 64'(bus.state), 64'h0);
    chk("async_rst_dval", 64'(bus.dval), 64'h0);
    chk("async_rst_dout", 64'(bus.dout), 64'h0);
    chk("async_rst_bad", 64'(bus.bad_bits), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cyc();
    chk("post_rst_idle", 64'(bus.state), 64'h0);
    chk("post_rst_bad", 64'(bus.bad_bits), 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
